// File: rtl/fifo_arbiter_pkg.sv
// fifo_arbiter_pkg
// Shared definitions for the FIFO arbiter slice:
//   - read-side FSM state encoding (IDLE / FETCH / HOLD)
//   - default data width, requester count and requester index width
package fifo_arbiter_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_REQ_BITS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rdState_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin selector.
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - index where the search for a set request starts
//   enable - when low no grant is issued
//   gnt    - one-hot grant (all zero when disabled or nothing requested)
module rr_arbiter #(
    parameter int nreq     = 4,
    parameter int req_bits = 2
) (
    input  logic [nreq-1:0]     req,
    input  logic [req_bits-1:0] rr_ptr,
    input  logic                enable,
    output logic [nreq-1:0]     gnt
);

    logic [req_bits-1:0] idx;
    logic                found;

    // Walk the requesters starting at rr_ptr and wrapping around; the first
    // set request wins. Starting at the slot after the last winner is what
    // keeps a continuously requesting lane from starving.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < nreq; off++) begin
            idx = req_bits'((int'(rr_ptr) + off) % nreq);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter
// Sits between several write requesters and a FIFO on the write side, and
// between the FIFO and a single valid/ready consumer on the read side.
// Ports:
//   clk, rst          - clock and synchronous active-low reset
//   req, req_data     - per-requester write request and data lanes
//   gnt               - one-hot write grant back to the requesters
//   write, data_in    - FIFO write strobe and write data
//   full, empthy      - FIFO status flags
//   read, data_out    - FIFO read strobe and read data (one cycle latency)
//   out_valid/out_data/out_ready - consumer handshake
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int width    = DEF_WIDTH,
    parameter int nreq     = DEF_NREQ,
    parameter int req_bits = DEF_REQ_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*width-1:0] req_data,
    output logic [nreq-1:0]       gnt,
    output logic                  write,
    output logic [width-1:0]      data_in,
    input  logic                  full,
    input  logic                  empthy,
    output logic                  read,
    input  logic [width-1:0]      data_out,
    output logic                  out_valid,
    output logic [width-1:0]      out_data,
    input  logic                  out_ready
);

    logic [req_bits-1:0] rrPtr_q, rrPtr_d;
    rdState_e            state_q, state_d;
    logic                outValid_q, outValid_d;
    logic [width-1:0]    outData_q, outData_d;
    logic                arbEnable;

    // Grants are suppressed combinationally while the FIFO is full or the
    // block is held in reset, so no write can slip out in either case.
    assign arbEnable = rst & ~full;

    rr_arbiter #(
        .nreq     (nreq),
        .req_bits (req_bits)
    ) uArbiter (
        .req    (req),
        .rr_ptr (rrPtr_q),
        .enable (arbEnable),
        .gnt    (gnt)
    );

    assign write = |gnt;

    // Steer the granted lane onto the FIFO write bus and move the round-robin
    // pointer to the slot just after the winner; without a grant both the
    // bus stays at zero and the pointer holds.
    always_comb begin
        data_in = '0;
        rrPtr_d = rrPtr_q;
        for (int i = 0; i < nreq; i++) begin
            if (gnt[i]) begin
                data_in = req_data[i*width +: width];
                rrPtr_d = req_bits'((i + 1) % nreq);
            end
        end
    end

    // Read-side FSM: IDLE issues a single-cycle read when data is available,
    // FETCH captures the FIFO word that arrives one cycle later, HOLD
    // presents it until the consumer accepts. Reading only from IDLE keeps
    // at most one word in flight.
    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        read       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst && !empthy) begin
                    read    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                outData_d  = data_out;
                outValid_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; a reset in FETCH or HOLD simply drops the in-flight
    // word rather than trying to replay it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrPtr_q    <= '0;
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            state_q    <= state_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter
// Directed bench for fifo_arbiter with a scoreboard: stimulus pushes the
// expected write grants/data and consumer words into queues, and a monitor
// pops and compares whenever the DUT writes or hands a word to the consumer.
module tb_fifo_arbiter;
    import fifo_arbiter_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int RB = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    gnt;
    logic            write;
    logic [W-1:0]    data_in;
    logic            full;
    logic            empthy;
    logic            read;
    logic [W-1:0]    data_out;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [W-1:0] data;
    } wrExp_t;

    wrExp_t     wrQ[$];
    logic [W-1:0] rdQ[$];
    int         checks = 0;
    int         errors = 0;

    fifo_arbiter #(
        .width    (W),
        .nreq     (N),
        .req_bits (RB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .write     (write),
        .data_in   (data_in),
        .full      (full),
        .empthy    (empthy),
        .read      (read),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                                 input logic f, input logic e, input logic rdy);
        rst       = r;
        req       = rq;
        full      = f;
        empthy    = e;
        out_ready = rdy;
    endtask

    task automatic pushWr(input logic [N-1:0] g, input logic [W-1:0] d);
        wrExp_t x;
        x.gnt  = g;
        x.data = d;
        wrQ.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Monitor: on every falling edge, match DUT writes and consumer
    // acceptances against the queued expectations.
    initial begin : monitor
        wrExp_t exp;
        logic [W-1:0] rexp;
        forever begin
            @(negedge clk);
            if (write) begin
                if (wrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: gnt %0h data %0h, expected no write", gnt, data_in);
                end else begin
                    exp = wrQ.pop_front();
                    checkOutput("sb_gnt", 32'(gnt), 32'(exp.gnt));
                    checkOutput("sb_data_in", 32'(data_in), 32'(exp.data));
                end
            end
            if (out_valid && out_ready) begin
                if (rdQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_consume: got %0h, expected no word", out_data);
                end else begin
                    rexp = rdQ.pop_front();
                    checkOutput("sb_out_data", 32'(out_data), 32'(rexp));
                end
            end
            checkOutput("read_while_valid", 32'(read & out_valid), 32'd0);
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin : stimulus
        req_data = 16'h4321;
        data_out = '0;
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);

        repeat (2) begin
            tick();
            settle();
            checkOutput("rst_gnt", 32'(gnt), 32'd0);
            checkOutput("rst_write", 32'(write), 32'd0);
            checkOutput("rst_read", 32'(read), 32'd0);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        end

        tick();
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
        pushWr(4'b0001, 4'd1);
        pushWr(4'b0010, 4'd2);
        pushWr(4'b0100, 4'd3);
        pushWr(4'b1000, 4'd4);
        pushWr(4'b0001, 4'd1);
        repeat (5) tick();
        checkOutput("rr_ptr_after_fair", 32'(dut.rrPtr_q), 32'd1);
        req = 4'b0000;
        settle();
        checkOutput("idle_write", 32'(write), 32'd0);
        checkOutput("idle_data_in", 32'(data_in), 32'd0);

        tick();
        req = 4'b1000;
        pushWr(4'b1000, 4'd4);
        tick();
        applyStimulus(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1);
        repeat (5) begin
            settle();
            checkOutput("full_gnt", 32'(gnt), 32'd0);
            checkOutput("full_write", 32'(write), 32'd0);
            checkOutput("full_rr_ptr", 32'(dut.rrPtr_q), 32'd0);
            tick();
        end
        full = 1'b0;
        pushWr(4'b0001, 4'd1);
        pushWr(4'b0100, 4'd3);
        tick();
        tick();
        req = 4'b0000;
        settle();
        checkOutput("rr_ptr_after_full", 32'(dut.rrPtr_q), 32'd3);

        tick();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        data_out = 4'hA;
        rdQ.push_back(4'hA);
        settle();
        checkOutput("rd_idle_read", 32'(read), 32'd1);
        checkOutput("rd_idle_valid", 32'(out_valid), 32'd0);
        tick();
        settle();
        checkOutput("rd_fetch_read", 32'(read), 32'd0);
        checkOutput("rd_fetch_valid", 32'(out_valid), 32'd0);
        tick();
        data_out = 4'h5;
        rdQ.push_back(4'h5);
        settle();
        checkOutput("rd_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("rd_hold_data", 32'(out_data), 32'hA);
        checkOutput("rd_hold_read", 32'(read), 32'd0);
        tick();
        out_ready = 1'b0;
        settle();
        checkOutput("rd_second_read", 32'(read), 32'd1);
        checkOutput("rd_second_valid", 32'(out_valid), 32'd0);
        tick();
        empthy = 1'b1;
        settle();
        checkOutput("bp_fetch_read", 32'(read), 32'd0);
        tick();
        data_out = 4'hF;
        repeat (6) begin
            settle();
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_data_stable", 32'(out_data), 32'h5);
            checkOutput("bp_read", 32'(read), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
        tick();
        settle();
        checkOutput("bp_after_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_after_state", 32'(dut.state_q), 32'(IDLE));

        tick();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        data_out = 4'h7;
        tick();
        empthy = 1'b1;
        tick();
        settle();
        checkOutput("mr_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("mr_hold_data", 32'(out_data), 32'h7);
        tick();
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);
        settle();
        checkOutput("mr_gnt", 32'(gnt), 32'd0);
        checkOutput("mr_write", 32'(write), 32'd0);
        checkOutput("mr_read", 32'(read), 32'd0);
        tick();
        settle();
        checkOutput("mr_valid", 32'(out_valid), 32'd0);
        checkOutput("mr_data", 32'(out_data), 32'd0);
        checkOutput("mr_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("mr_rr_ptr", 32'(dut.rrPtr_q), 32'd0);
        tick();
        rst = 1'b1;
        pushWr(4'b0001, 4'd1);
        tick();
        req = 4'b0000;
        out_ready = 1'b1;

        repeat (3) tick();
        settle();
        checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 The parameters SHALL be, one per line as name, default, meaning:
- width, 4, FIFO data word width in bits.
- nreq, 4, number of write requesters (2..8).
- req_bits, 2, requester index width, clog2(nreq).

REQ-002 The ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-low reset.
- req, in, nreq, write request per requester, level-held until granted.
- req_data, in, nreq*width, write data; lane i is bits [i*width +: width].
- gnt, out, nreq, one-hot write grant; requester i drops or advances data after a gnt[i] cycle.
- write, out, 1, FIFO write strobe.
- data_in, out, width, FIFO write data.
- full, in, 1, FIFO full flag.
- empthy, in, 1, FIFO empty flag.
- read, out, 1, FIFO read strobe.
- data_out, in, width, FIFO read data, valid the cycle after read.
- out_valid, out, 1, consumer data valid.
- out_data, out, width, consumer data.
- out_ready, in, 1, consumer accept.

Function
REQ-003 The write-side grant SHALL be combinational from req, full and the round-robin pointer rr_ptr.
REQ-004 When full=1 or req=0, gnt SHALL be 0 and write SHALL be 0.
REQ-005 Otherwise, gnt SHALL select the first set req bit, searching from index rr_ptr upward and wrapping modulo nreq.
REQ-006 In a grant cycle, write SHALL be 1 and data_in SHALL equal the granted lane of req_data.
REQ-007 When write=0, data_in SHALL be 0.
REQ-008 On each grant to index i, rr_ptr SHALL become (i+1) mod nreq; with no grant, rr_ptr SHALL hold.
REQ-009 A continuously requesting requester SHALL be granted within nreq non-full cycles (no starvation).
REQ-010 The read side SHALL be an FSM with three states: IDLE, FETCH and HOLD.
REQ-011 IDLE SHALL go to FETCH when empthy=0, with read=1 for that cycle only; otherwise it SHALL stay in IDLE.
REQ-012 FETCH SHALL latch data_out into out_data, set out_valid=1, and go to HOLD.
REQ-013 HOLD SHALL keep out_valid=1 and out_data stable while out_ready=0.
REQ-014 In HOLD with out_ready=1, out_valid SHALL be 0 on the next edge and the FSM SHALL go to IDLE.
REQ-015 read SHALL be asserted only in IDLE, so at most one read is outstanding and read never occurs while out_valid=1.
REQ-016 Minimum read throughput SHALL be one word per 3 cycles.
REQ-017 Write and read sides SHALL operate independently; a grant and a read in the same cycle are legal.
REQ-018 The block SHALL NOT gate write with empthy or gate read with full.

Reset
REQ-019 While rst=0 at a rising edge, the following SHALL be cleared on that edge: rr_ptr=0, FSM=IDLE, out_valid=0, out_data=0.
REQ-020 While rst=0, gnt, write and read SHALL be forced to 0 combinationally.
REQ-021 Reset asserted in FETCH or HOLD SHALL discard the in-flight word; no replay after reset.

Structure
REQ-022 A shared package/include SHALL hold the FSM state encodings (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2) and default width/nreq constants.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, rr_ptr, enable; output one-hot gnt).
REQ-024 The FSM, rr_ptr register and output register SHALL reside in fifo_arbiter.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset: rst=0 for 2 cycles with req=4'b1111, empthy=0 -> gnt=0, write=0, read=0, out_valid=0; after release, first gnt=4'b0001.
- Fairness: req=4'b1111, full=0, lanes 1,2,3,4 -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; data_in 1,2,3,4,1.
- Full stall: req=4'b0101, full=1 for 5 cycles -> gnt=0, write=0, rr_ptr unchanged; full=0 -> gnt=0001, then 0100.
- Read path: empthy=0, out_ready=1, data_out=4'hA the cycle after read -> read pulses 1 cycle, out_valid=1 with out_data=4'hA from the next edge, then IDLE and the next read 3 cycles after the first.
- Backpressure: out_ready=0 for 6 cycles in HOLD -> out_data stable, read=0 throughout; out_ready=1 -> out_valid=0 next edge.
- Mid-operation reset: rst=0 during HOLD with req active -> out_valid=0 and FSM=IDLE next edge, gnt=0 immediately, rr_ptr=0.
